// File: rtl/data_mem_ctrl.sv
// Data-memory controller: serialises 32-bit MEM-stage loads/stores onto an 8-bit RAM port,
// one selected byte lane per cycle, stalling the pipeline through busy_o.
//   state  | meaning
//   IDLE   | waiting for mem_ce_i; request latched on acceptance
//   ACCESS | one selected lane per cycle, ascending
//   WAIT   | load only: capture the last byte returned by the RAM
//   DONE   | result valid, busy_o low, pipeline advances
module data_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        busy_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  sel_q;
    logic [31:0] data_q;
    logic [1:0]  lane_q;
    logic        rd_pend_q;
    logic [1:0]  rd_lane_q;
    logic [31:0] mem_data_q;

    logic [3:0]  above_mask;
    logic [3:0]  remaining;
    logic        last_lane;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^mem_addr_i[1:0];

    function automatic logic [1:0] lowest_lane(input logic [3:0] s);
        logic [1:0] l;
        l = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (s[i]) l = 2'(i);
        end
        return l;
    endfunction

    always_comb begin
        case (lane_q)
            2'd0:    above_mask = 4'b1110;
            2'd1:    above_mask = 4'b1100;
            2'd2:    above_mask = 4'b1000;
            default: above_mask = 4'b0000;
        endcase
    end

    assign remaining = sel_q & above_mask;
    assign last_lane = (remaining == 4'b0000);

    always_comb begin
        state_d    = state_q;
        busy_o     = 1'b0;
        ram_wr_o   = 1'b0;
        ram_addr_o = 32'h0;
        ram_dout_o = 8'h0;
        case (state_q)
            ST_IDLE: begin
                busy_o = mem_ce_i;
                if (mem_ce_i) begin
                    state_d = (mem_sel_i == 4'b0000) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy_o     = 1'b1;
                ram_addr_o = {addr_q, lane_q};
                ram_wr_o   = we_q;
                ram_dout_o = we_q ? data_q[{lane_q, 3'b000} +: 8] : 8'h0;
                if (last_lane) begin
                    state_d = we_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy_o  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= 30'h0;
            sel_q      <= 4'h0;
            data_q     <= 32'h0;
            lane_q     <= 2'd0;
            rd_pend_q  <= 1'b0;
            rd_lane_q  <= 2'd0;
            mem_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (mem_ce_i) begin
                        we_q       <= mem_we_i;
                        addr_q     <= mem_addr_i[31:2];
                        sel_q      <= mem_sel_i;
                        data_q     <= mem_data_i;
                        lane_q     <= lowest_lane(mem_sel_i);
                        rd_pend_q  <= 1'b0;
                        mem_data_q <= 32'h0;
                    end
                end
                ST_ACCESS: begin
                    // RAM returns the byte one cycle after its address, so capture lags issue by one lane
                    if (rd_pend_q) begin
                        mem_data_q[{rd_lane_q, 3'b000} +: 8] <= ram_din_i;
                    end
                    rd_pend_q <= ~we_q;
                    rd_lane_q <= lane_q;
                    if (!last_lane) begin
                        lane_q <= lowest_lane(remaining);
                    end
                end
                ST_WAIT: begin
                    if (rd_pend_q) begin
                        mem_data_q[{rd_lane_q, 3'b000} +: 8] <= ram_din_i;
                    end
                    rd_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-wide RAM model plus a cycle-trace reference
// built from the lane-serialisation rules, with directed and random requests.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        busy_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .busy_o     (busy_o),
        .ram_addr_o (ram_addr_o),
        .ram_wr_o   (ram_wr_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din_i)
    );

    // Synchronous byte RAM: read data appears the cycle after the address
    always @(posedge clk) begin
        if (ram_wr_o) begin
            mem[ram_addr_o[9:0]] <= ram_dout_o;
            wr_count <= wr_count + 1;
        end else begin
            ram_din_i <= mem[ram_addr_o[9:0]];
        end
    end

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, input bit hold, input string tag);
        logic [1:0]  lanes[$];
        logic [41:0] exp_tr[$];
        logic [41:0] obs;
        logic [31:0] exp_data;
        logic [31:0] a;
        exp_data = 32'h0;
        for (int l = 0; l < 4; l++) begin
            if (sel[l]) lanes.push_back(2'(l));
        end
        exp_tr.push_back({1'b1, 1'b0, 32'h0, 8'h0});
        foreach (lanes[k]) begin
            a = {addr[31:2], lanes[k]};
            exp_tr.push_back({1'b1, we, a, we ? data[int'(lanes[k]) * 8 +: 8] : 8'h0});
            if (!we) exp_data[int'(lanes[k]) * 8 +: 8] = mem[a[9:0]];
        end
        if (!we && lanes.size() > 0) exp_tr.push_back({1'b1, 1'b0, 32'h0, 8'h0});
        exp_tr.push_back({1'b0, 1'b0, 32'h0, 8'h0});

        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
        for (int c = 0; c < exp_tr.size(); c++) begin
            #1;
            obs = {busy_o, ram_wr_o, ram_addr_o, (exp_tr[c][40] ? ram_dout_o : 8'h00)};
            total++;
            if (obs !== exp_tr[c]) begin
                bad++;
                $display("FAIL %s cycle %0d: {busy,wr,addr,dout} got %h want %h", tag, c, obs, exp_tr[c]);
            end
            if (c == exp_tr.size() - 1) begin
                total++;
                if (mem_data_o !== exp_data) begin
                    bad++;
                    $display("FAIL %s data: got %h want %h", tag, mem_data_o, exp_data);
                end
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                mem_we_i   = 1'($urandom);
                mem_addr_i = $urandom;
                mem_sel_i  = 4'($urandom);
                mem_data_i = $urandom;
            end
        end
        if (!hold) begin
            mem_ce_i = 1'b0;
            #1;
            total++;
            if ({busy_o, mem_data_o} !== {1'b0, exp_data}) begin
                bad++;
                $display("FAIL %s hold: {busy,data} got %h want %h", tag, {busy_o, mem_data_o}, {1'b0, exp_data});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ce_i = 1'b0;
        mem_we_i = 1'b0;
        mem_addr_i = 32'h0;
        mem_sel_i = 4'h0;
        mem_data_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy_o, ram_wr_o, ram_addr_o, ram_dout_o, mem_data_o} !== 74'h0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b wr=%b addr=%h dout=%h data=%h want all 0",
                     busy_o, ram_wr_o, ram_addr_o, ram_dout_o, mem_data_o);
        end
        mem_ce_i = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy_follows_ce: got %b want 1", busy_o);
        end
        mem_ce_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        run_txn(1'b0, 32'h0000_0100, 4'b1111, $urandom, 1'b0, "lw_0x100");
        total++;
        if (mem_data_o !== 32'h4433_2211) begin
            bad++;
            $display("FAIL lw_value: got %h want 44332211", mem_data_o);
        end
        run_txn(1'b1, 32'h0000_0203, 4'b1000, 32'hA5A5_A5A5, 1'b0, "sb_0x203");
        total++;
        if (mem[10'h203] !== 8'hA5) begin
            bad++;
            $display("FAIL sb_ram_byte: got %h want a5", mem[10'h203]);
        end
        mem[10'h042] = 8'h80; mem[10'h043] = 8'hFF;
        run_txn(1'b0, 32'h0000_0042, 4'b1100, $urandom, 1'b0, "lh_0x42");
        total++;
        if (mem_data_o !== 32'hFF80_0000) begin
            bad++;
            $display("FAIL lh_value: got %h want ff800000", mem_data_o);
        end
        run_txn(1'b0, 32'h0000_0080, 4'b0000, $urandom, 1'b0, "sel_zero");
        run_txn(1'b1, 32'h0000_0150, 4'b1010, 32'hDEAD_BEEF, 1'b0, "sw_1010");
        run_txn(1'b0, 32'h0000_0150, 4'b1010, $urandom, 1'b0, "lw_1010");
    endtask

    task automatic test_back_to_back();
        int wc0;
        @(posedge clk);
        #1;
        wc0 = wr_count;
        run_txn(1'b1, 32'h0000_0220, 4'b1111, 32'h1234_5678, 1'b1, "b2b_first");
        run_txn(1'b1, 32'h0000_0220, 4'b1111, 32'h1234_5678, 1'b0, "b2b_second");
        @(posedge clk);
        #1;
        total++;
        if (wr_count - wc0 !== 8) begin
            bad++;
            $display("FAIL b2b_write_count: got %0d want 8", wr_count - wc0);
        end
    endtask

    task automatic test_reset_abort();
        int wc0;
        mem[10'h300] = 8'h5A;
        run_txn(1'b0, 32'h0000_0300, 4'b0001, $urandom, 1'b0, "pre_abort_lb");
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_addr_i = 32'h0000_0304;
        mem_sel_i  = 4'b1111;
        mem_data_i = 32'hCAFE_F00D;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total++;
        if ({ram_wr_o, ram_addr_o} !== {1'b1, 32'h0000_0306}) begin
            bad++;
            $display("FAIL abort_third_access: {wr,addr} got %h want 100000306", {ram_wr_o, ram_addr_o});
        end
        rst = 1'b1;
        mem_ce_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wc0 = wr_count;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({busy_o, ram_wr_o, mem_data_o} !== 34'h0) begin
                bad++;
                $display("FAIL abort_after_reset cycle %0d: busy=%b wr=%b data=%h want 0 0 0",
                         i, busy_o, ram_wr_o, mem_data_o);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (wr_count !== wc0) begin
            bad++;
            $display("FAIL abort_writes: got %0d extra want 0", wr_count - wc0);
        end
        run_txn(1'b0, 32'h0000_0300, 4'b0001, $urandom, 1'b0, "post_abort_lb");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), $urandom, 4'($urandom), $urandom, 1'b0, $sformatf("rand_%0d", i));
            if ($urandom_range(1, 0) == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        ram_din_i = 8'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset; sampled on rising clk edge.
REQ-004 mem_ce_i  input  1  request valid from MEM stage; held stable while busy_o=1.
REQ-005 mem_we_i  input  1  1 = store, 0 = load.
REQ-006 mem_addr_i  input  32  byte address of request; only [31:2] used for word selection.
REQ-007 mem_sel_i  input  4  byte-lane enables; bit k selects bits [8k+7:8k].
REQ-008 mem_data_i  input  32  store data, already replicated into lanes by MEM stage.
REQ-009 mem_data_o  output  32  load result; selected lanes hold RAM bytes, unselected lanes 0.
REQ-010 busy_o  output  1  stall to MEM stage (fetching_data).
REQ-011 ram_addr_o  output  32  byte address to 8-bit RAM port.
REQ-012 ram_wr_o  output  1  1 = write ram_dout_o this cycle, 0 = read.
REQ-013 ram_dout_o  output  8  write byte.
REQ-014 ram_din_i  input  8  read byte, valid one cycle after its address is presented with ram_wr_o=0.

Function
REQ-015 FSM states: IDLE, ACCESS, WAIT, DONE.
REQ-016 IDLE: busy_o = mem_ce_i (combinational); on mem_ce_i=1, latch we, addr[31:2], sel, data, clear mem_data_o to 0, set lane pointer to lowest selected lane, go ACCESS; if sel=0, go DONE directly.
REQ-017 ACCESS: one selected lane per cycle in ascending order; ram_addr_o = {addr[31:2], lane}; busy_o=1.
REQ-018 ACCESS store: ram_wr_o=1, ram_dout_o = latched data[8*lane+7:8*lane]; after last lane go DONE.
REQ-019 ACCESS load: ram_wr_o=0; ram_din_i captured next cycle into mem_data_o lane of previously issued address (reads pipelined back-to-back); after last lane go WAIT.
REQ-020 WAIT: capture final byte into mem_data_o, busy_o=1, ram_wr_o=0, go DONE.
REQ-021 DONE: busy_o=0, mem_data_o valid, no RAM traffic; go IDLE unconditionally (edge consumed by pipeline advance, so no re-issue of same request).
REQ-022 Cycles from request acceptance to DONE inclusive: 2 + n + (load?1:0), n = popcount(sel); LW = 7, SW = 6, LB = 4, SB = 3.
REQ-023 Inputs changing while busy_o=1 SHALL be ignored; only latched values used.
REQ-024 Outside ACCESS: ram_wr_o=0, ram_addr_o=0, ram_dout_o=0.
REQ-025 mem_data_o SHALL hold its value from DONE until the next request is accepted in IDLE.
REQ-026 Non-contiguous sel (e.g. 4'b1010) SHALL access only lanes 1 and 3.

Reset
REQ-027 On rst=1: state IDLE, lane pointer 0, latched request cleared, mem_data_o=0, ram_wr_o=0, ram_addr_o=0, ram_dout_o=0; busy_o then follows mem_ce_i.
REQ-028 rst asserted mid-ACCESS SHALL abort with no further RAM writes from the next cycle; partial load bytes discarded.

Verification
REQ-029 LW addr=0x100, sel=1111, RAM 0x100..0x103 = 11,22,33,44 -> addresses 0x100..0x103 on consecutive cycles, busy 6 cycles, DONE mem_data_o=0x44332211.
REQ-030 SB addr=0x203, sel=1000, data=0xA5A5A5A5 -> one cycle ram_wr_o=1, ram_addr_o=0x203, ram_dout_o=0xA5; busy 2 cycles then DONE.
REQ-031 LH addr=0x42, sel=1100, RAM 0x42=0x80, 0x43=0xFF -> mem_data_o=0xFF800000 in DONE, 4 cycles busy... 5 cycles total.
REQ-032 Two back-to-back identical SW requests -> exactly 8 RAM writes total, IDLE cycle between DONE and second acceptance.
REQ-033 rst pulse during third ACCESS cycle of SW -> no ram_wr_o after reset cycle, mem_data_o=0, FSM IDLE.
REQ-034 mem_ce_i=1 with sel=0000 -> no RAM traffic, busy 1 cycle, DONE mem_data_o=0.
